// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller: 4-digit multiplexed seven-segment driver.
// Scans one digit per refresh slot with inter-digit blanking and debounced digit masks.
//
// Ports:
//   clock               system clock, all state on rising edge
//   resetN              asynchronous active-low reset
//   displayValue[15:0]  value to show, nibble i -> digit i (digit 0 rightmost)
//   decimalPoints[3:0]  bit i lights the dp of digit i
//   controlButtons[3:0] raw async buttons, button i toggles digit i mask
//   sevenSegmentData    {dp,g,f,e,d,c,b,a}, active-low, registered
//   sevenSegmentEnable  digit anodes, active-low, registered
//   digitMask           per-digit enable mask (1 = shown)
//   frameStart          one-cycle pulse after a new frame value is latched
module seven_segment_scan_controller #(
    parameter int REFRESH_DIV     = 1000,
    parameter int BLANK_CYCLES    = 50,
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic [15:0] displayValue,
    input  logic [3:0]  decimalPoints,
    input  logic [3:0]  controlButtons,
    output logic [7:0]  sevenSegmentData,
    output logic [3:0]  sevenSegmentEnable,
    output logic [3:0]  digitMask,
    output logic        frameStart
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END = PW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

    logic [PW-1:0] prescaler;
    logic [1:0]    digit;
    logic [15:0]   valueLatch;
    logic [3:0]    dpLatch;
    logic          slotEnd;
    logic          frameEnd;

    logic [3:0]    syncA;
    logic [3:0]    syncB;
    logic [3:0]    stable;
    logic [3:0]    stableD;
    logic [DW-1:0] dbCount [4];

    logic [3:0]    nibble;
    logic [3:0]    enableNext;
    logic [7:0]    dataNext;

    function automatic logic [6:0] hexSeg(input logic [3:0] n);
        case (n)
            4'h0:    hexSeg = 7'h40;
            4'h1:    hexSeg = 7'h79;
            4'h2:    hexSeg = 7'h24;
            4'h3:    hexSeg = 7'h30;
            4'h4:    hexSeg = 7'h19;
            4'h5:    hexSeg = 7'h12;
            4'h6:    hexSeg = 7'h02;
            4'h7:    hexSeg = 7'h78;
            4'h8:    hexSeg = 7'h00;
            4'h9:    hexSeg = 7'h10;
            4'hA:    hexSeg = 7'h08;
            4'hB:    hexSeg = 7'h03;
            4'hC:    hexSeg = 7'h46;
            4'hD:    hexSeg = 7'h21;
            4'hE:    hexSeg = 7'h06;
            default: hexSeg = 7'h0E;
        endcase
    endfunction

    assign slotEnd  = (prescaler == PRE_LAST);
    assign frameEnd = slotEnd && (digit == 2'd3);

    // Scan counters and frame latch; inputs are only captured at frame wrap.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            prescaler  <= '0;
            digit      <= 2'd0;
            valueLatch <= 16'h0000;
            dpLatch    <= 4'h0;
            frameStart <= 1'b0;
        end else begin
            frameStart <= frameEnd;
            if (slotEnd) begin
                prescaler <= '0;
                digit     <= digit + 2'd1;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
            if (frameEnd) begin
                valueLatch <= displayValue;
                dpLatch    <= decimalPoints;
            end
        end
    end

    // Two-flop synchronizer then a per-bit hold counter.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            syncA   <= 4'h0;
            syncB   <= 4'h0;
            stable  <= 4'h0;
            stableD <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                dbCount[i] <= '0;
            end
        end else begin
            syncA   <= controlButtons;
            syncB   <= syncA;
            stableD <= stable;
            for (int i = 0; i < 4; i++) begin
                if (syncB[i] == stable[i]) begin
                    dbCount[i] <= '0;
                end else if (dbCount[i] == DB_LAST) begin
                    stable[i]  <= syncB[i];
                    dbCount[i] <= '0;
                end else begin
                    dbCount[i] <= dbCount[i] + DW'(1);
                end
            end
        end
    end

    // Only the accepted rising edge flips a mask bit, so one press = one toggle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            digitMask <= 4'hF;
        end else begin
            digitMask <= digitMask ^ (stable & ~stableD);
        end
    end

    always_comb begin
        nibble     = valueLatch[{digit, 2'b00} +: 4];
        enableNext = 4'hF;
        dataNext   = 8'hFF;
        if ((prescaler >= BLANK_END) && digitMask[digit]) begin
            enableNext = ~(4'b0001 << digit);
            dataNext   = {~dpLatch[digit], hexSeg(nibble)};
        end
    end

    // Reset drives the pins dark immediately, independent of the clock.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sevenSegmentEnable <= 4'hF;
            sevenSegmentData   <= 8'hFF;
        end else begin
            sevenSegmentEnable <= enableNext;
            sevenSegmentData   <= dataNext;
        end
    end

endmodule
